// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU issue controller:
//   - alu_op_e   : ALU control encodings (ADD..NOP)
//   - cond_e     : ARM-style condition codes (EQ..AL)
//   - FLAG_*     : bit positions of N/Z/C/V inside a 4-bit flag vector
//   - state_e    : issue FSM states
//   - op_illegal : true for control codes above NOP
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_SLL = 4'd4,
        OP_SRL = 4'd5,
        OP_XOR = 4'd6,
        OP_MUL = 4'd7,
        OP_NOP = 4'd8
    } alu_op_e;

    typedef enum logic [3:0] {
        CC_EQ = 4'd0,
        CC_NE = 4'd1,
        CC_CS = 4'd2,
        CC_CC = 4'd3,
        CC_MI = 4'd4,
        CC_PL = 4'd5,
        CC_VS = 4'd6,
        CC_VC = 4'd7,
        CC_HI = 4'd8,
        CC_LS = 4'd9,
        CC_GE = 4'd10,
        CC_LT = 4'd11,
        CC_GT = 4'd12,
        CC_LE = 4'd13,
        CC_AL = 4'd14
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    // Control codes past NOP have no ALU meaning and are issued as NOP.
    function automatic logic op_illegal(input logic [3:0] op);
        return (op > 4'(OP_NOP));
    endfunction

endpackage

// File: rtl/cond_check.sv
// -----------------------------------------------------------------------------
// cond_check
// Combinational ARM-style condition evaluator.
// Ports:
//   cond  in  4  condition code (EQ..LE, E/F = always)
//   flags in  4  architectural flags [3]=N [2]=Z [1]=C [0]=V
//   pass  out 1  1 when the condition holds for the given flags
// -----------------------------------------------------------------------------
module cond_check
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n_s;
    logic z_s;
    logic c_s;
    logic v_s;

    assign n_s = flags[FLAG_N];
    assign z_s = flags[FLAG_Z];
    assign c_s = flags[FLAG_C];
    assign v_s = flags[FLAG_V];

    // Condition decode; codes 14 and 15 both mean "always".
    always_comb begin
        pass = 1'b1;
        case (cond)
            4'(CC_EQ): pass = z_s;
            4'(CC_NE): pass = ~z_s;
            4'(CC_CS): pass = c_s;
            4'(CC_CC): pass = ~c_s;
            4'(CC_MI): pass = n_s;
            4'(CC_PL): pass = ~n_s;
            4'(CC_VS): pass = v_s;
            4'(CC_VC): pass = ~v_s;
            4'(CC_HI): pass = c_s & ~z_s;
            4'(CC_LS): pass = ~c_s | z_s;
            4'(CC_GE): pass = (n_s == v_s);
            4'(CC_LT): pass = (n_s != v_s);
            4'(CC_GT): pass = ~z_s & (n_s == v_s);
            4'(CC_LE): pass = z_s | (n_s != v_s);
            default:   pass = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Initiator side of the combinational ALU. Accepts one request at a time,
// drives registered operands/control to the ALU, holds them for the op's
// latency (MUL_LAT cycles for multiply, one otherwise), captures the result
// and flags, and returns a response. Owns the architectural NZCV register and
// evaluates the request condition against it at accept time.
// Ports:
//   clk, rst_n                clock / async active-low reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_op/a/b/cond/setflags/tag  request payload
//   alu_a/alu_b/alu_control   registered drive to the ALU
//   alu_result/alu_flags      ALU outputs
//   resp_valid/resp_ready     response handshake
//   resp_result/flags/exec/err/tag  response payload
//   flags_q                   current architectural flags
// -----------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 3,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_cond,
    input  logic             req_setflags,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic [3:0]       resp_flags,
    output logic             resp_exec,
    output logic             resp_err,
    output logic [TAG_W-1:0] resp_tag,
    output logic [3:0]       flags_q
);

    localparam logic [1:0] ST_IDLE = S_IDLE;
    localparam logic [1:0] ST_EXEC = S_EXEC;
    localparam logic [1:0] ST_WAIT = S_WAIT;
    localparam logic [1:0] ST_RESP = S_RESP;

    // A multiply only needs the WAIT state when it must be held past EXEC.
    localparam logic     MUL_MULTI = (MUL_LAT > 1) ? 1'b1 : 1'b0;
    localparam int       CNT_W     = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             pass_r;
    logic             err_r;
    logic             setflags_r;
    logic [TAG_W-1:0] tag_r;

    logic             cond_pass_s;
    logic             accept_s;
    logic             is_mul_s;
    logic             capture_s;
    logic             squash_s;
    logic             upd_flags_s;
    logic [3:0]       next_flags_s;

    cond_check u_cond_check (
        .cond  (req_cond),
        .flags (flags_q),
        .pass  (cond_pass_s)
    );

    // Handshake, capture and flag-update qualifiers.
    always_comb begin
        accept_s     = (state_r == ST_IDLE) && req_valid;
        is_mul_s     = (alu_control == 4'(OP_MUL));
        squash_s     = (state_r == ST_EXEC) && !pass_r;
        capture_s    = ((state_r == ST_EXEC) && pass_r && !(is_mul_s && MUL_MULTI)) ||
                       ((state_r == ST_WAIT) && (cnt_r == CNT_ONE));
        // err_r already forced control to NOP; both terms kept for clarity.
        upd_flags_s  = setflags_r && !err_r && (alu_control != 4'(OP_NOP));
        if (upd_flags_s) begin
            next_flags_s = alu_flags;
        end else begin
            next_flags_s = flags_q;
        end
    end

    // Next-state logic for the single-outstanding issue FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (!pass_r) begin
                    state_nxt_s = ST_RESP;
                end else if (is_mul_s && MUL_MULTI) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_r == CNT_ONE) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register; req_ready is registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            req_ready <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            req_ready <= (state_nxt_s == ST_IDLE);
        end
    end

    // Request capture: ALU drive registers plus request side-band.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a       <= {WIDTH{1'b0}};
            alu_b       <= {WIDTH{1'b0}};
            alu_control <= 4'(OP_NOP);
            pass_r      <= 1'b0;
            err_r       <= 1'b0;
            setflags_r  <= 1'b0;
            tag_r       <= {TAG_W{1'b0}};
        end else if (accept_s) begin
            alu_a       <= req_a;
            alu_b       <= req_b;
            alu_control <= op_illegal(req_op) ? 4'(OP_NOP) : req_op;
            pass_r      <= cond_pass_s;
            err_r       <= op_illegal(req_op);
            setflags_r  <= req_setflags;
            tag_r       <= req_tag;
        end
    end

    // Multiply hold counter: loaded at end of EXEC, counts down through WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_EXEC) && pass_r && is_mul_s && MUL_MULTI) begin
            cnt_r <= CNT_LOAD;
        end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r - CNT_ONE;
        end
    end

    // Flag register and response payload; resp_* stay stable until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q     <= 4'b0000;
            resp_valid  <= 1'b0;
            resp_result <= {WIDTH{1'b0}};
            resp_flags  <= 4'b0000;
            resp_exec   <= 1'b0;
            resp_err    <= 1'b0;
            resp_tag    <= {TAG_W{1'b0}};
        end else if (capture_s) begin
            flags_q     <= next_flags_s;
            resp_valid  <= 1'b1;
            resp_result <= alu_result;
            resp_flags  <= next_flags_s;
            resp_exec   <= 1'b1;
            resp_err    <= err_r;
            resp_tag    <= tag_r;
        end else if (squash_s) begin
            resp_valid  <= 1'b1;
            resp_result <= {WIDTH{1'b0}};
            resp_flags  <= flags_q;
            resp_exec   <= 1'b0;
            resp_err    <= err_r;
            resp_tag    <= tag_r;
        end else if ((state_r == ST_RESP) && resp_ready) begin
            resp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Directed bench for alu_issue_ctrl with a behavioural ALU and a scoreboard of
// expected responses built from an independent flag/condition model.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    localparam int WIDTH   = 32;
    localparam int MUL_LAT = 3;
    localparam int TAG_W   = 4;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [3:0]       req_cond;
    logic             req_setflags;
    logic [TAG_W-1:0] req_tag;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_result;
    logic [3:0]       resp_flags;
    logic             resp_exec;
    logic             resp_err;
    logic [TAG_W-1:0] resp_tag;
    logic [3:0]       flags_q;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  flags;
        logic        exec;
        logic        err;
        logic [3:0]  tag;
    } exp_t;

    exp_t        sbq[$];
    logic [3:0]  mflags;
    int          total;
    int          passed;
    logic [35:0] alu_bus;
    logic [3:0]  sweep_conds [0:8] = '{4'h2, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'h4, 4'h3};

    alu_issue_ctrl #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cond(req_cond),
        .req_setflags(req_setflags), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_flags(resp_flags),
        .resp_exec(resp_exec), .resp_err(resp_err), .resp_tag(resp_tag),
        .flags_q(flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: {result, N, Z, C, V}; sub C is the borrow, NOP yields zeros.
    function automatic logic [35:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        cy;
        logic        v;
        w = 33'd0; r = 32'd0; cy = 1'b0; v = 1'b0;
        case (c)
            4'd0: begin
                w  = {1'b0, a} + {1'b0, b};
                r  = w[31:0];
                cy = w[32];
                v  = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'd1: begin
                r  = a - b;
                cy = (a < b);
                v  = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a << b[4:0];
            4'd5: r = a >> b[4:0];
            4'd6: r = a ^ b;
            4'd7: r = a * b;
            default: return 36'd0;
        endcase
        return {r, r[31], (r == 32'd0), cy, v};
    endfunction

    function automatic logic cond_ok(input logic [3:0] f, input logic [3:0] cond);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    always_comb begin
        alu_bus    = alu_fn(alu_control, alu_a, alu_b);
        alu_result = alu_bus[35:4];
        alu_flags  = alu_bus[3:0];
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    // One full transaction; hold = cycles resp_ready stays low once resp_valid is seen.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] cond, input logic sf, input logic [3:0] tag, input int hold);
        exp_t        e;
        exp_t        got;
        logic [35:0] r;
        logic [3:0]  ctrl;
        logic [31:0] snap;
        int          lat;
        int          mulcnt;
        int          exp_lat;
        ctrl   = (op > 4'd8) ? 4'd8 : op;
        r      = alu_fn(ctrl, a, b);
        e.err  = (op > 4'd8);
        e.exec = cond_ok(mflags, cond);
        e.tag  = tag;
        if (e.exec) begin
            e.result = r[35:4];
            if (sf && !e.err && ctrl != 4'd8) mflags = r[3:0];
        end else begin
            e.result = 32'd0;
        end
        e.flags = mflags;
        sbq.push_back(e);
        exp_lat = (e.exec && ctrl == 4'd7) ? MUL_LAT + 1 : 2;

        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        req_cond = cond; req_setflags = sf; req_tag = tag;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; mulcnt = 0;
        chk("alu_control", {28'd0, alu_control}, {28'd0, ctrl});
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        while (!resp_valid && lat < 20) begin
            if (alu_control == 4'd7) mulcnt++;
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        if (exp_lat != 2) chk("mul_hold", mulcnt, MUL_LAT);

        snap = resp_result;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_op = 4'h6; req_a = 32'hDEAD; req_b = 32'hBEEF;
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            chk("hold_result", resp_result, snap);
            chk("hold_alu_ctrl", {28'd0, alu_control}, {28'd0, ctrl});
        end
        req_valid = 1'b0;

        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sbq.pop_front();
            chk("resp_result", resp_result, got.result);
            chk("resp_flags", {28'd0, resp_flags}, {28'd0, got.flags});
            chk("resp_exec", {31'd0, resp_exec}, {31'd0, got.exec});
            chk("resp_err", {31'd0, resp_err}, {31'd0, got.err});
            chk("resp_tag", {28'd0, resp_tag}, {28'd0, got.tag});
            chk("flags_q", {28'd0, flags_q}, {28'd0, mflags});
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("resp_drop", {31'd0, resp_valid}, 32'd0);
        chk("ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; passed = 0; mflags = 4'd0;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_a = 32'd0; req_b = 32'd0;
        req_cond = 4'd0; req_setflags = 1'b0; req_tag = 4'd0; resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu_control", {28'd0, alu_control}, 32'd8);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_result", resp_result, 32'd0);
        chk("rst_resp_flags", {28'd0, resp_flags}, 32'd0);
        chk("rst_flags_q", {28'd0, flags_q}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // sub 5-5 with setflags: Z only
        do_op(4'd1, 32'd5, 32'd5, 4'hE, 1'b1, 4'd1, 0);
        chk("t1_flags", {28'd0, flags_q}, 32'h4);
        // flag dependency: EQ executes, NE squashes
        do_op(4'd0, 32'd1, 32'd2, 4'h0, 1'b0, 4'd2, 0);
        do_op(4'd0, 32'd1, 32'd2, 4'h1, 1'b1, 4'd3, 0);
        chk("t2_flags", {28'd0, flags_q}, 32'h4);
        // multiply held MUL_LAT cycles
        do_op(4'd7, 32'd6, 32'd7, 4'hE, 1'b0, 4'd4, 0);
        // back-pressure in RESP with junk requests presented
        do_op(4'd6, 32'hF0F0, 32'h0FF0, 4'hE, 1'b0, 4'd5, 5);
        // illegal op: NOP on the ALU, error flagged, flags untouched
        do_op(4'hC, 32'd9, 32'd9, 4'hE, 1'b1, 4'd6, 0);
        chk("t5_flags", {28'd0, flags_q}, 32'h4);
        // shifts
        do_op(4'd4, 32'd3, 32'd4, 4'hF, 1'b0, 4'd7, 0);
        do_op(4'd5, 32'h8000_0000, 32'd31, 4'hE, 1'b0, 4'd8, 0);
        // 1-2 sets N and borrow-C, then sweep conditions against 4'b1010
        do_op(4'd1, 32'd1, 32'd2, 4'hE, 1'b1, 4'd9, 0);
        chk("neg_flags", {28'd0, flags_q}, 32'hA);
        for (int i = 0; i < 9; i++) begin
            do_op(4'd0, 32'(i), 32'd1, sweep_conds[i], 1'b0, sweep_conds[i], 0);
        end
        // signed overflow: N and V set
        do_op(4'd0, 32'h7FFF_FFFF, 32'd1, 4'hE, 1'b1, 4'd10, 0);
        chk("ovf_flags", {28'd0, flags_q}, 32'h9);
        do_op(4'd2, 32'hFF, 32'h0F, 4'hA, 1'b0, 4'd11, 0);
        do_op(4'd3, 32'hF0, 32'h0F, 4'hB, 1'b0, 4'd12, 0);
        do_op(4'd7, 32'd3, 32'd5, 4'h0, 1'b1, 4'd13, 0);

        // reset while a multiply is in WAIT
        req_valid = 1'b1; req_op = 4'd7; req_a = 32'd3; req_b = 32'd3;
        req_cond = 4'hE; req_setflags = 1'b1; req_tag = 4'd14;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("t6_in_wait", {28'd0, alu_control}, 32'd7);
        rst_n = 1'b0;
        #1;
        chk("t6_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("t6_flags_q", {28'd0, flags_q}, 32'd0);
        chk("t6_req_ready", {31'd0, req_ready}, 32'd1);
        chk("t6_alu_control", {28'd0, alu_control}, 32'd8);
        mflags = 4'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(4'd0, 32'd10, 32'd20, 4'hE, 1'b1, 4'd15, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
